// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - instruction fetch FSM with PC, branch redirect, stall, halt and fault detection
// Optional feature macro: FETCH_COUNTER_EN (enables the saturating fetch_count register)
module instruction_fetch_unit #(
  parameter int          INSTRUCTION_MEM_SIZE = 128,
  parameter logic [31:0] START_PC             = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic [31:0] instruction,
  output logic [31:0] address,
  output logic [31:0] instr_out,
  output logic [5:0]  opcode,
  output logic [5:0]  funcode,
  output logic        instr_valid,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  // First byte address past the end of instruction memory; 33 bits so the compare never wraps.
  localparam logic [32:0] PC_LIMIT = 33'(4 * INSTRUCTION_MEM_SIZE);
  localparam logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC;
  localparam logic [31:0] RESET_INSTR = 32'hFC00_0000;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_q, instr_n;
  logic        valid_q, valid_n;
  logic        fault_q, fault_n;

  logic pc_oob;
  logic halt_word;

  assign pc_oob    = ({1'b0, pc} >= PC_LIMIT);
  assign halt_word = (instruction[31:26] == 6'b111111);

  // Next-state and datapath decisions; range check beats halt word, halt word beats branch.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    instr_n = instr_q;
    valid_n = 1'b0;
    fault_n = fault_q;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_PC;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (pc_oob) begin
            state_n = S_HALT;
            fault_n = 1'b1;
          end else if (halt_word) begin
            state_n = S_HALT;
            instr_n = instruction;
          end else begin
            instr_n = instruction;
            valid_n = 1'b1;
            if (branch_taken) begin
              pc_n = {branch_target[31:2], 2'b00};
              if (branch_target[1:0] != 2'b00) fault_n = 1'b1;
            end else begin
              pc_n = pc + 32'd4;
            end
          end
        end
      end
      S_HALT: begin
        state_n = S_HALT;
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  // State, PC and output registers; reset discards any in-flight fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      instr_q <= RESET_INSTR;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      instr_q <= instr_n;
      valid_q <= valid_n;
      fault_q <= fault_n;
    end
  end

`ifdef FETCH_COUNTER_EN
  logic [31:0] count_q;

  // Count each delivered instruction, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 32'd0;
    end else if (valid_n && (count_q != 32'hFFFF_FFFF)) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`else
  assign fetch_count = 32'd0;
`endif

  assign address     = (state == S_IDLE) ? IDLE_ADDR : pc;
  assign instr_out   = instr_q;
  assign opcode      = instr_q[31:26];
  assign funcode     = instr_q[5:0];
  assign instr_valid = valid_q;
  assign halted      = (state == S_HALT);
  assign fault       = fault_q;

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter INSTRUCTION_MEM_SIZE, default 128, instruction memory depth in 32-bit words.
REQ-002 SHALL have parameter START_PC, default 32'h0000_0000, first fetch address after start.
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, single-cycle pulse that begins fetching from IDLE.
REQ-006 SHALL have port stall, input, 1, holds PC and output registers while high.
REQ-007 SHALL have port branch_taken, input, 1, redirects PC to branch_target in the same cycle as the current fetch.
REQ-008 SHALL have port branch_target, input, 32, byte address of the redirect.
REQ-009 SHALL have port instruction, input, 32, word returned combinationally by instruction memory for address.
REQ-010 SHALL have port address, output, 32, byte fetch address to instruction memory.
REQ-011 SHALL have port instr_out, output, 32, registered fetched word.
REQ-012 SHALL have port opcode, output, 6, instr_out[31:26].
REQ-013 SHALL have port funcode, output, 6, instr_out[5:0].
REQ-014 SHALL have port instr_valid, output, 1, instr_out holds a new non-halt instruction this cycle.
REQ-015 SHALL have port halted, output, 1, high in HALT.
REQ-016 SHALL have port fault, output, 1, sticky flag for out-of-range or misaligned fetch.
REQ-017 SHALL have port fetch_count, output, 32, count of valid instructions delivered.

Function
REQ-018 SHALL implement three states: IDLE, RUN, HALT.
REQ-019 IDLE: address SHALL be 32'hFFFF_FFFC (-4, memory init code); instr_valid 0; start moves to RUN with PC = START_PC.
REQ-020 RUN: address SHALL equal PC combinationally; with stall low, each edge captures instruction into instr_out and sets instr_valid 1; the fetched word is therefore visible one cycle after its address.
REQ-021 RUN, stall low, no branch: PC SHALL advance by 4; wrap on 32-bit overflow is not permitted and is caught by REQ-025.
REQ-022 RUN, stall low, branch_taken high: next PC SHALL be {branch_target[31:2],2'b00}; a nonzero branch_target[1:0] sets fault but the fetch continues.
REQ-023 RUN, stall high: PC, instr_out and fetch_count SHALL hold; instr_valid SHALL be 0; branch_taken ignored.
REQ-024 Halt word: an instruction with [31:26] = 6'b111111 in RUN with stall low SHALL move to HALT; instr_out loads the halt word, instr_valid stays 0; halt has priority over a simultaneous branch_taken.
REQ-025 PC >= 4*INSTRUCTION_MEM_SIZE in RUN SHALL move to HALT with fault set, without capturing instruction.
REQ-026 HALT: address and PC SHALL hold; instr_valid 0; halted 1; only reset exits HALT; start ignored.
REQ-027 start in RUN or HALT SHALL be ignored.

Reset
REQ-028 rst_n low SHALL immediately, independent of clk, force IDLE, PC = START_PC, instr_out = 32'hFC00_0000, instr_valid 0, halted 0, fault 0, fetch_count 0.
REQ-029 Reset asserted mid-RUN SHALL discard any in-flight fetch; address returns to -4 while rst_n is low.
REQ-030 opcode and funcode after reset SHALL read 6'b111111 and 6'b000000.

Configuration
REQ-031 With macro FETCH_COUNTER_EN defined, fetch_count SHALL increment by 1 on every cycle with instr_valid 1 and saturate at 32'hFFFF_FFFF.
REQ-032 Without FETCH_COUNTER_EN, fetch_count SHALL be constant 0 and no counter register synthesized; all other behaviour unchanged.

Verification
REQ-033 Reset, start, memory words 0..2 = ADD, SUB, 32'hFC00_0000 -> addresses 0,4,8; instr_valid for two cycles; halted 1 at cycle 4; fetch_count 2 (macro on).
REQ-034 branch_taken with target 32'h0000_0010 while fetching address 4 -> next address 16; instr_out sequence word1 then word4.
REQ-035 stall held 3 cycles at address 8 -> address stays 8, instr_valid 0 for 3 cycles, instr_out unchanged, then resumes at 12.
REQ-036 Branch to 32'h0000_0201 (size 128) -> fault 1, next address 32'h0000_0200, then HALT with no capture.
REQ-037 rst_n low mid-RUN at address 12 between clock edges -> address -4, IDLE, all outputs at reset values before next edge.
REQ-038 Halt word and branch_taken in same cycle -> HALT entered, address held, no redirect.
